// File: rtl/acct_verifier.sv
// acct_verifier: collects 4-digit account/PIN entries, searches the account table, checks PINs (PIN_LOCKOUT_EN adds per-account lockout)
module acct_verifier #(
  parameter logic [15:0] ACCT0 = 16'h1234,
  parameter logic [15:0] ACCT1 = 16'h2468,
  parameter logic [15:0] ACCT2 = 16'h3579,
  parameter logic [15:0] ACCT3 = 16'h9876,
  parameter logic [15:0] PIN0  = 16'h1111,
  parameter logic [15:0] PIN1  = 16'h2222,
  parameter logic [15:0] PIN2  = 16'h3333,
  parameter logic [15:0] PIN3  = 16'h4444
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] fsm_state,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       key_clear,
  output logic [3:0] status_code,
  output logic [1:0] acct_idx,
  output logic [2:0] digit_count,
  output logic       busy,
  output logic [3:0] locked
);
  localparam logic [3:0] FSM_ACC = 4'b0010;
  localparam logic [3:0] FSM_PIN = 4'b0011;
  localparam logic [3:0] ST_FOUND = 4'b0001;
  localparam logic [3:0] ST_NOT_FOUND = 4'b0010;
  localparam logic [3:0] ST_PIN_OK = 4'b0011;
  localparam logic [3:0] ST_PIN_BAD = 4'b0100;

  typedef enum logic [2:0] {IDLE, ACC_COLLECT, ACC_LOOKUP, PIN_COLLECT, PIN_CHECK} state_t;

  state_t      state_q, state_d;
  logic [15:0] buf_q, buf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  acct_q, acct_d;
  logic [3:0]  status_q, status_d;
  logic        found_q, found_d;
  logic [3:0]  lock_v;
  logic [15:0] acct_tab [4];
  logic [15:0] pin_tab [4];
  logic        collecting, abort, clr, take, last, hit, pin_ok;

  assign acct_tab = '{ACCT0, ACCT1, ACCT2, ACCT3};
  assign pin_tab  = '{PIN0, PIN1, PIN2, PIN3};

  // leaving the fsm_state that owns the current collect state wins over any keypad activity
  assign collecting = state_q == ACC_COLLECT || state_q == PIN_COLLECT;
  assign abort = (state_q == ACC_COLLECT && fsm_state != FSM_ACC) ||
                 (state_q == PIN_COLLECT && fsm_state != FSM_PIN);
  assign clr  = collecting && !abort && key_clear;
  assign take = collecting && !abort && !key_clear && digit_valid && digit <= 4'd9;
  assign last = take && cnt_q == 3'd3;
  assign hit    = buf_q == acct_tab[ptr_q] && !lock_v[ptr_q];
  assign pin_ok = buf_q == pin_tab[acct_q];

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      acct_q   <= '0;
      status_q <= '0;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      acct_q   <= acct_d;
      status_q <= status_d;
      found_q  <= found_d;
    end
  end

  // next-state: collect until the 4th digit, then one lookup/check pass back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        state_d = fsm_state == FSM_ACC ? ACC_COLLECT :
                             (fsm_state == FSM_PIN && found_q) ? PIN_COLLECT : IDLE;
      ACC_COLLECT: state_d = abort ? IDLE : last ? ACC_LOOKUP : ACC_COLLECT;
      PIN_COLLECT: state_d = abort ? IDLE : last ? PIN_CHECK : PIN_COLLECT;
      ACC_LOOKUP:  state_d = (hit || ptr_q == 2'd3) ? IDLE : ACC_LOOKUP;
      PIN_CHECK:   state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // datapath and the registered one-cycle response
  always_comb begin
    buf_d    = state_d == IDLE ? 16'h0 : clr ? 16'h0 : take ? {buf_q[11:0], digit} : buf_q;
    cnt_d    = state_d == IDLE ? 3'd0 : clr ? 3'd0 : take ? cnt_q + 3'd1 : cnt_q;
    ptr_d    = (state_q == ACC_LOOKUP && state_d == ACC_LOOKUP) ? ptr_q + 2'd1 : 2'd0;
    status_d = state_q == ACC_LOOKUP ? (hit ? ST_FOUND : ptr_q == 2'd3 ? ST_NOT_FOUND : 4'd0) :
               state_q == PIN_CHECK ? (pin_ok ? ST_PIN_OK : ST_PIN_BAD) : 4'd0;
    acct_d   = (state_q == ACC_LOOKUP && hit) ? ptr_q : acct_q;
    found_d  = found_q || (state_q == ACC_LOOKUP && hit);
  end

`ifdef PIN_LOCKOUT_EN
  logic [1:0] fail_q [4];
  logic [1:0] fail_d [4];
  logic [3:0] locked_q, locked_d;

  // saturating fail counters; three wrong PINs lock the account until reset
  always_comb begin
    fail_d   = fail_q;
    locked_d = locked_q;
    if (state_q == PIN_CHECK && !pin_ok) begin
      fail_d[acct_q]   = fail_q[acct_q] == 2'd3 ? 2'd3 : fail_q[acct_q] + 2'd1;
      locked_d[acct_q] = locked_q[acct_q] || fail_d[acct_q] == 2'd3;
    end else if (state_q == PIN_CHECK && !locked_q[acct_q]) begin
      fail_d[acct_q] = 2'd0;
    end
  end

  // lockout registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_q   <= '{default: 2'd0};
      locked_q <= '0;
    end else begin
      fail_q   <= fail_d;
      locked_q <= locked_d;
    end
  end

  assign lock_v = locked_q;
`else
  assign lock_v = 4'b0000;
`endif

  assign status_code = status_q;
  assign acct_idx    = acct_q;
  assign digit_count = cnt_q;
  assign busy        = state_q == ACC_LOOKUP || state_q == PIN_CHECK || status_q != 4'd0;
  assign locked      = lock_v;
endmodule

// File: tb/tb_acct_verifier.sv
// tb_acct_verifier: directed and randomized checks of acct_verifier against a table-search reference model
module tb_acct_verifier;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] fsm_state = 4'd0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       key_clear = 1'b0;
  logic [3:0] status_code;
  logic [1:0] acct_idx;
  logic [2:0] digit_count;
  logic       busy;
  logic [3:0] locked;
  int checks = 0;
  int failures = 0;

`ifdef PIN_LOCKOUT_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic [15:0] acct_tab [4] = '{16'h1234, 16'h2468, 16'h3579, 16'h9876};
  logic [15:0] pin_tab  [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  bit         m_found;
  logic [1:0] m_idx;
  logic [3:0] m_locked;
  int         m_fail [4];

  acct_verifier dut (
    .clk(clk), .rst_n(rst_n), .fsm_state(fsm_state), .digit_valid(digit_valid),
    .digit(digit), .key_clear(key_clear), .status_code(status_code), .acct_idx(acct_idx),
    .digit_count(digit_count), .busy(busy), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_found = 0;
    m_idx = 0;
    m_locked = 0;
    for (int k = 0; k < 4; k++) m_fail[k] = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; fsm_state = 0; digit_valid = 0; key_clear = 0; digit = 0;
    tick(); tick();
    rst_n = 1;
    tick();
    model_clear();
  endtask

  task automatic model_acct(input logic [15:0] num, output logic [3:0] c, output int l);
    c = 4'b0010;
    l = 5;
    for (int k = 0; k < 4; k++)
      if (acct_tab[k] == num && !m_locked[k]) begin
        c = 4'b0001; l = 2 + k; m_idx = k[1:0]; m_found = 1;
        break;
      end
  endtask

  task automatic model_pin(input logic [15:0] num, output logic [3:0] c);
    c = num == pin_tab[m_idx] ? 4'b0011 : 4'b0100;
    if (LOCK) begin
      if (c == 4'b0100) begin
        if (m_fail[m_idx] < 3) m_fail[m_idx]++;
        if (m_fail[m_idx] == 3) m_locked[m_idx] = 1'b1;
      end else if (!m_locked[m_idx]) m_fail[m_idx] = 0;
    end
  endtask

  task automatic go_mode(input logic [3:0] m);
    fsm_state = m;
    tick(); tick(); tick();
  endtask

  // keys in four digits (optionally with an ignored 4'hA and fsm_state noise during lookup)
  // and records the first response within an 8-cycle budget
  task automatic enter(input logic [15:0] num, input bit junk, input bit wiggle,
                       output logic [3:0] code, output int lat, output int nresp,
                       output logic [1:0] idx, output bit busy_bad);
    logic [3:0] orig;
    orig = fsm_state;
    code = 0; lat = 0; nresp = 0; idx = acct_idx; busy_bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (junk && i == 2) begin digit_valid = 1; digit = 4'hA; tick(); end
      if ($urandom_range(0, 3) == 0) begin digit_valid = 0; tick(); end
      if (busy !== 1'b0) busy_bad = 1;
      digit_valid = 1; digit = num[15-4*i -: 4];
      tick();
    end
    digit_valid = 0;
    for (int n = 1; n <= 8; n++) begin
      if (status_code !== 4'd0) begin
        nresp++;
        if (lat == 0) begin lat = n; code = status_code; idx = acct_idx; end
      end
      if (busy !== (lat == 0 || n == lat)) busy_bad = 1;
      if (lat == 0) begin
        digit_valid = 1'($urandom_range(0, 1)); digit = 4'($urandom_range(0, 9));
        key_clear = 1'($urandom_range(0, 1));
        if (wiggle) fsm_state = 4'($urandom_range(0, 15));
      end else begin
        digit_valid = 0; key_clear = 0; fsm_state = orig;
      end
      tick();
    end
    digit_valid = 0; key_clear = 0; fsm_state = orig;
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(); tick();
    checks++; if (status_code !== 4'd0) begin failures++; $display("FAIL reset_status got=%h exp=0", status_code); end
    checks++; if (acct_idx !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", acct_idx); end
    checks++; if (digit_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", digit_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (locked !== 4'd0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
    rst_n = 1;
    tick();
    model_clear();
  endtask

  task automatic test_acc_lookup();
    logic [15:0] nums [3] = '{16'h1234, 16'h9876, 16'h5555};
    logic [3:0] c, ec; int l, el, nr; logic [1:0] idx; bit bb;
    go_mode(4'b0010);
    foreach (nums[j]) begin
      enter(nums[j], 0, 0, c, l, nr, idx, bb);
      model_acct(nums[j], ec, el);
      checks++; if (c !== ec) begin failures++; $display("FAIL acc_code num=%h got=%h exp=%h", nums[j], c, ec); end
      checks++; if (l != el) begin failures++; $display("FAIL acc_latency num=%h got=%0d exp=%0d", nums[j], l, el); end
      checks++; if (nr != 1) begin failures++; $display("FAIL acc_resp_count num=%h got=%0d exp=1", nums[j], nr); end
      checks++; if (idx !== m_idx) begin failures++; $display("FAIL acc_idx num=%h got=%0d exp=%0d", nums[j], idx, m_idx); end
      checks++; if (bb) begin failures++; $display("FAIL acc_busy num=%h got=wrong exp=high through response", nums[j]); end
    end
  endtask

  task automatic test_pin();
    logic [3:0] c, ec; int l, el, nr; logic [1:0] idx; bit bb;
    go_mode(4'b0010);
    enter(16'h2468, 0, 0, c, l, nr, idx, bb);
    model_acct(16'h2468, ec, el);
    checks++; if (c !== 4'b0001 || idx !== 2'd1) begin failures++; $display("FAIL pin_setup got=%h/%0d exp=1/1", c, idx); end
    go_mode(4'b0011);
    enter(16'h2222, 0, 0, c, l, nr, idx, bb);
    model_pin(16'h2222, ec);
    checks++; if (c !== 4'b0011 || c !== ec) begin failures++; $display("FAIL pin_correct got=%h exp=3", c); end
    checks++; if (l != 2 || nr != 1 || bb) begin failures++; $display("FAIL pin_correct_timing got=lat%0d/n%0d/busybad%0d exp=lat2/n1/0", l, nr, bb); end
    enter(16'h2223, 0, 0, c, l, nr, idx, bb);
    model_pin(16'h2223, ec);
    checks++; if (c !== 4'b0100 || c !== ec) begin failures++; $display("FAIL pin_incorrect got=%h exp=4", c); end
    checks++; if (l != 2 || nr != 1 || bb) begin failures++; $display("FAIL pin_incorrect_timing got=lat%0d/n%0d/busybad%0d exp=lat2/n1/0", l, nr, bb); end
  endtask

  task automatic test_clear();
    logic [3:0] c, ec; int l, el, nr; logic [1:0] idx; bit bb;
    go_mode(4'b0010);
    digit_valid = 1; digit = 4'd1; tick();
    digit = 4'd2; tick();
    digit_valid = 0;
    checks++; if (digit_count !== 3'd2) begin failures++; $display("FAIL clear_pre got=%0d exp=2", digit_count); end
    key_clear = 1; digit_valid = 1; digit = 4'd7; tick();
    key_clear = 0; digit_valid = 0;
    checks++; if (digit_count !== 3'd0) begin failures++; $display("FAIL clear_post got=%0d exp=0", digit_count); end
    digit_valid = 1; digit = 4'hC; tick();
    digit_valid = 0;
    checks++; if (digit_count !== 3'd0) begin failures++; $display("FAIL clear_bad_digit got=%0d exp=0", digit_count); end
    enter(16'h3579, 1, 0, c, l, nr, idx, bb);
    model_acct(16'h3579, ec, el);
    checks++; if (c !== 4'b0001 || l != 4 || nr != 1) begin failures++; $display("FAIL clear_lookup got=%h/lat%0d/n%0d exp=1/lat4/n1", c, l, nr); end
    checks++; if (idx !== 2'd2) begin failures++; $display("FAIL clear_idx got=%0d exp=2", idx); end
  endtask

  task automatic test_abort();
    int nz;
    go_mode(4'b0010);
    digit_valid = 1; digit = 4'd9; tick();
    digit = 4'd8; tick();
    digit_valid = 0;
    checks++; if (digit_count !== 3'd2) begin failures++; $display("FAIL abort_pre got=%0d exp=2", digit_count); end
    fsm_state = 4'b0001;
    tick();
    checks++; if (digit_count !== 3'd0) begin failures++; $display("FAIL abort_count got=%0d exp=0", digit_count); end
    nz = 0;
    for (int n = 0; n < 6; n++) begin
      if (status_code !== 4'd0 || busy !== 1'b0) nz++;
      tick();
    end
    checks++; if (nz != 0) begin failures++; $display("FAIL abort_quiet got=%0d active cycles exp=0", nz); end
  endtask

  task automatic test_reset_mid_lookup();
    int nz;
    go_mode(4'b0010);
    for (int i = 0; i < 4; i++) begin digit_valid = 1; digit = 4'(9 - i); tick(); end
    digit_valid = 0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midreset_busy got=%b exp=1", busy); end
    #2 rst_n = 0;
    #1;
    checks++; if ({status_code, acct_idx, digit_count, busy, locked} !== 14'd0) begin
      failures++; $display("FAIL midreset_outputs got=%h exp=0", {status_code, acct_idx, digit_count, busy, locked}); end
    @(posedge clk); #1 rst_n = 1;
    model_clear();
    nz = 0;
    for (int n = 0; n < 6; n++) begin
      if (status_code !== 4'd0) nz++;
      tick();
    end
    checks++; if (nz != 0) begin failures++; $display("FAIL midreset_suppress got=%0d responses exp=0", nz); end
  endtask

  task automatic test_lockout();
    logic [3:0] c, ec; int l, el, nr; logic [1:0] idx; bit bb;
    do_reset();
    go_mode(4'b0010);
    enter(16'h1234, 0, 0, c, l, nr, idx, bb);
    model_acct(16'h1234, ec, el);
    checks++; if (c !== 4'b0001) begin failures++; $display("FAIL lock_setup got=%h exp=1", c); end
    go_mode(4'b0011);
    for (int t = 0; t < 3; t++) begin
      enter(16'h1112, 0, 0, c, l, nr, idx, bb);
      model_pin(16'h1112, ec);
      checks++; if (c !== 4'b0100) begin failures++; $display("FAIL lock_wrong_pin try=%0d got=%h exp=4", t, c); end
    end
    checks++; if (locked !== (LOCK ? 4'b0001 : 4'b0000)) begin failures++; $display("FAIL lock_flags got=%b exp=%b", locked, LOCK ? 4'b0001 : 4'b0000); end
    go_mode(4'b0010);
    enter(16'h1234, 0, 0, c, l, nr, idx, bb);
    model_acct(16'h1234, ec, el);
    checks++; if (c !== (LOCK ? 4'b0010 : 4'b0001) || l != (LOCK ? 5 : 2)) begin
      failures++; $display("FAIL lock_relookup got=%h/lat%0d exp=%h/lat%0d", c, l, LOCK ? 4'b0010 : 4'b0001, LOCK ? 5 : 2); end
  endtask

  task automatic test_random();
    logic [3:0] c, ec; int l, el, nr; logic [1:0] idx; bit bb; logic [15:0] num;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) num = acct_tab[$urandom_range(0, 3)];
      else for (int d = 0; d < 4; d++) num = {num[11:0], 4'($urandom_range(0, 9))};
      go_mode(4'b0010);
      enter(num, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c, l, nr, idx, bb);
      model_acct(num, ec, el);
      checks++; if (c !== ec || l != el || nr != 1) begin failures++; $display("FAIL rnd_acct num=%h got=%h/lat%0d/n%0d exp=%h/lat%0d/n1", num, c, l, nr, ec, el); end
      checks++; if (idx !== m_idx || bb) begin failures++; $display("FAIL rnd_acct_idx num=%h got=%0d busybad=%0d exp=%0d", num, idx, bb, m_idx); end
      if (m_found && $urandom_range(0, 1) == 1) begin
        num = $urandom_range(0, 1) == 1 ? pin_tab[m_idx] : {4'd1, 4'($urandom_range(0, 9)), 4'd0, 4'($urandom_range(0, 9))};
        go_mode(4'b0011);
        enter(num, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c, l, nr, idx, bb);
        model_pin(num, ec);
        checks++; if (c !== ec || l != 2 || nr != 1 || bb) begin failures++; $display("FAIL rnd_pin num=%h got=%h/lat%0d/n%0d/busybad%0d exp=%h/lat2/n1/0", num, c, l, nr, bb, ec); end
        checks++; if (locked !== m_locked) begin failures++; $display("FAIL rnd_locked got=%b exp=%b", locked, m_locked); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_acc_lookup();
    test_pin();
    test_clear();
    test_abort();
    test_reset_mid_lookup();
    test_lockout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
